vm_proj_buffer: RTL

VM_PROJ_BUFFER -- requirements
Module: vm_proj_buffer

---
 rtl/vm_proj_buffer_if.sv | 26 ++
 rtl/vm_proj_buffer.sv | 103 ++++++++++
 2 files changed

// File: rtl/vm_proj_buffer_if.sv
// Handshake bundle between the VM projection router, the ping-pong buffer
// and the downstream match engine.
interface vm_proj_buffer_if #(
  parameter int unsigned DATA_W = 13,
  parameter int unsigned ADDR_W = 6
);
  logic              start;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_empty;
  logic [ADDR_W:0]   nproj_rd;
  logic              ovf_rd;

  modport master (
    output start, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, rd_empty, nproj_rd, ovf_rd
  );

  modport slave (
    input  start, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, rd_empty, nproj_rd, ovf_rd
  );
endinterface

// File: rtl/vm_proj_buffer.sv
// Two-page (ping-pong) event buffer for VM projection words: one page fills
// while the other is drained; start swaps the pages at the event boundary.
module vm_proj_buffer #(
  parameter int unsigned DATA_W = 13,
  parameter int unsigned ADDR_W = 6
) (
  input logic              clk,
  input logic              reset,
  vm_proj_buffer_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [0:2*DEPTH-1];

  logic              r_wr_page;
  logic [ADDR_W:0]   r_wr_cnt;
  logic              r_wr_ovf;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [ADDR_W:0]   r_nproj_rd;
  logic              r_ovf_rd;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  logic              w_wr_full;
  logic              w_rd_empty;
  logic              w_rd_accept;
  logic              w_mem_we;
  logic [ADDR_W:0]   w_mem_waddr;
  logic [ADDR_W:0]   w_mem_raddr;

  assign w_wr_full   = r_wr_cnt[ADDR_W];
  assign w_rd_empty  = (r_rd_ptr == r_nproj_rd);
  assign w_rd_accept = bus.rd_en && !w_rd_empty && !bus.start;
  assign w_mem_raddr = {~r_wr_page, r_rd_ptr[ADDR_W-1:0]};

  // A write coinciding with start lands at word 0 of the page that becomes
  // the write page on this very edge.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = '0;
    if (!reset && bus.wr_en) begin
      if (bus.start) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = {~r_wr_page, {ADDR_W{1'b0}}};
      end else if (!w_wr_full) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = {r_wr_page, r_wr_cnt[ADDR_W-1:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_page <= 1'b0;
      r_wr_cnt  <= '0;
      r_wr_ovf  <= 1'b0;
    end else if (bus.start) begin
      r_wr_page <= ~r_wr_page;
      r_wr_cnt  <= bus.wr_en ? {{ADDR_W{1'b0}}, 1'b1} : '0;
      r_wr_ovf  <= 1'b0;
    end else if (bus.wr_en) begin
      if (w_wr_full) begin
        r_wr_ovf <= 1'b1;
      end else begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_nproj_rd <= '0;
      r_ovf_rd   <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_accept;
      if (bus.start) begin
        r_rd_ptr   <= '0;
        r_nproj_rd <= r_wr_cnt;
        r_ovf_rd   <= r_wr_ovf;
      end else if (w_rd_accept) begin
        r_rd_data <= r_mem[w_mem_raddr];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_empty = w_rd_empty;
  assign bus.nproj_rd = r_nproj_rd;
  assign bus.ovf_rd   = r_ovf_rd;

endmodule
